// File: rtl/traffic_phase_fsm.sv
// Two-way intersection sequencer: green/yellow/all-red phases timed in sec_tick units,
// pedestrian early-cut with an extended walk all-red, and a flashing-yellow maintenance mode.
module traffic_phase_fsm #(
    parameter int TW            = 8,
    parameter int GREEN_SEC     = 20,
    parameter int YELLOW_SEC    = 3,
    parameter int ALLRED_SEC    = 2,
    parameter int MIN_GREEN_SEC = 5,
    parameter int WALK_SEC      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sec_tick,
    input  logic          ped_btn,
    input  logic          flash_en,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          walk,
    output logic [TW-1:0] phase_left,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_SEC - 1);
    localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_SEC - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_SEC - 1);
    localparam logic [TW-1:0] WALK_LD   = TW'(WALK_SEC - 1);
    // Green may be cut short once the timer has fallen to this value or below.
    localparam logic [TW-1:0] EARLY_MAX = TW'(GREEN_SEC - MIN_GREEN_SEC);

    localparam int DUR [5] = '{GREEN_SEC, YELLOW_SEC, ALLRED_SEC, MIN_GREEN_SEC, WALK_SEC};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dur_chk
            if (DUR[gi] < 1 || DUR[gi] >= (2 ** TW)) begin : g_bad_dur
                $error("traffic_phase_fsm: duration parameter %0d out of range", gi);
            end
        end
        if (MIN_GREEN_SEC > GREEN_SEC) begin : g_bad_min_green
            $error("traffic_phase_fsm: MIN_GREEN_SEC exceeds GREEN_SEC");
        end
    endgenerate

    state_t        state_reg, state_next, succ_state;
    logic [TW-1:0] timer_reg, timer_next;
    logic          ped_pend_reg, ped_pend_next;
    logic          walk_reg, walk_next;
    logic          flash_lit_reg, flash_lit_next;
    logic [2:0]    ns_light_reg, ns_light_next;
    logic [2:0]    ew_light_reg, ew_light_next;
    logic          is_green, phase_end;

    // State register; lamps are registered alongside so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ALL_RED2;
            timer_reg     <= ALLRED_LD;
            ped_pend_reg  <= 1'b0;
            walk_reg      <= 1'b0;
            flash_lit_reg <= 1'b0;
            ns_light_reg  <= LAMP_RED;
            ew_light_reg  <= LAMP_RED;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            ped_pend_reg  <= ped_pend_next;
            walk_reg      <= walk_next;
            flash_lit_reg <= flash_lit_next;
            ns_light_reg  <= ns_light_next;
            ew_light_reg  <= ew_light_next;
        end
    end

    assign is_green  = (state_reg == NS_GREEN) || (state_reg == EW_GREEN);
    assign phase_end = sec_tick && ((timer_reg == '0) ||
                       (is_green && ped_pend_reg && (timer_reg <= EARLY_MAX)));

    always_comb begin
        succ_state = ALL_RED2;
        case (state_reg)
            NS_GREEN:  succ_state = NS_YELLOW;
            NS_YELLOW: succ_state = ALL_RED1;
            ALL_RED1:  succ_state = EW_GREEN;
            EW_GREEN:  succ_state = EW_YELLOW;
            EW_YELLOW: succ_state = ALL_RED2;
            ALL_RED2:  succ_state = NS_GREEN;
            default:   succ_state = ALL_RED2;
        endcase
    end

    // Next-state logic: flash has priority, then phase termination, then countdown.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        ped_pend_next  = ped_pend_reg;
        walk_next      = walk_reg;
        flash_lit_next = flash_lit_reg;
        if (flash_en) begin
            if (state_reg != FLASH) begin
                state_next     = FLASH;
                timer_next     = '0;
                ped_pend_next  = 1'b0;
                walk_next      = 1'b0;
                flash_lit_next = 1'b1;
            end else if (sec_tick) begin
                flash_lit_next = ~flash_lit_reg;
            end
        end else if (state_reg == FLASH) begin
            state_next     = ALL_RED2;
            timer_next     = ALLRED_LD;
            walk_next      = 1'b0;
            flash_lit_next = 1'b0;
        end else begin
            if (ped_btn && !walk_reg) begin
                ped_pend_next = 1'b1;
            end
            if (phase_end) begin
                state_next = succ_state;
                walk_next  = 1'b0;
                case (succ_state)
                    NS_GREEN, EW_GREEN:   timer_next = GREEN_LD;
                    NS_YELLOW, EW_YELLOW: timer_next = YELLOW_LD;
                    default: begin
                        // Serving a request clears it on this edge, swallowing any coincident press.
                        if (ped_pend_reg) begin
                            timer_next    = WALK_LD;
                            walk_next     = 1'b1;
                            ped_pend_next = 1'b0;
                        end else begin
                            timer_next = ALLRED_LD;
                        end
                    end
                endcase
            end else if (sec_tick && (timer_reg != '0)) begin
                timer_next = timer_reg - 1'b1;
            end
        end
    end

    always_comb begin
        ns_light_next = LAMP_RED;
        ew_light_next = LAMP_RED;
        case (state_next)
            NS_GREEN:  ns_light_next = LAMP_GRN;
            NS_YELLOW: ns_light_next = LAMP_YEL;
            EW_GREEN:  ew_light_next = LAMP_GRN;
            EW_YELLOW: ew_light_next = LAMP_YEL;
            FLASH: begin
                ns_light_next = flash_lit_next ? LAMP_YEL : LAMP_OFF;
                ew_light_next = flash_lit_next ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign ns_light   = ns_light_reg;
    assign ew_light   = ew_light_reg;
    assign walk       = walk_reg;
    assign phase_left = timer_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: hand-derived tick-slot vectors, reset/hold corner cases,
// then random stimulus against a phase-table reference model.
module tb_traffic_phase_fsm;

    localparam int TW = 8;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int MG = 2;
    localparam int WK = 3;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] YL = 3'b010;
    localparam logic [2:0] GN = 3'b001;
    localparam logic [2:0] O  = 3'b000;

    logic          clk = 1'b0;
    logic          rst;
    logic          sec_tick;
    logic          ped_btn;
    logic          flash_en;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic          walk;
    logic [TW-1:0] phase_left;
    logic [2:0]    state_o;

    traffic_phase_fsm #(
        .TW(TW), .GREEN_SEC(G), .YELLOW_SEC(Y), .ALLRED_SEC(AR),
        .MIN_GREEN_SEC(MG), .WALK_SEC(WK)
    ) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .ped_btn(ped_btn),
        .flash_en(flash_en), .ns_light(ns_light), .ew_light(ew_light),
        .walk(walk), .phase_left(phase_left), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [2:0] st, logic [2:0] ns, logic [2:0] ew,
                         logic w, int left);
        checks++;
        if (state_o !== st || ns_light !== ns || ew_light !== ew || walk !== w ||
            phase_left !== TW'(left)) begin
            errors++;
            $display("FAIL %s: got state=%0d ns=%b ew=%b walk=%b left=%0d, expected state=%0d ns=%b ew=%b walk=%b left=%0d",
                     name, state_o, ns_light, ew_light, walk, phase_left, st, ns, ew, w, left);
        end
    endtask

    // Reference model: position in a six-phase table plus ticks elapsed in the phase.
    int seq_dur [6] = '{G, Y, AR, G, Y, AR};
    logic [2:0] lamp_ns [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] lamp_ew [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int m_phase, m_dur, m_elapsed;
    bit m_walk, m_pend, m_flash, m_lit;

    function automatic void model_reset();
        m_phase = 5; m_dur = AR; m_elapsed = 0;
        m_walk = 0; m_pend = 0; m_flash = 0; m_lit = 0;
    endfunction

    function automatic void model_step(bit t, bit p, bit f);
        bit ends;
        bit old_pend;
        if (f) begin
            if (!m_flash) begin
                m_flash = 1; m_lit = 1; m_pend = 0; m_walk = 0;
            end else if (t) begin
                m_lit = !m_lit;
            end
            return;
        end
        if (m_flash) begin
            m_flash = 0; m_phase = 5; m_dur = AR; m_elapsed = 0; m_walk = 0;
            return;
        end
        old_pend = m_pend;
        if (p && !m_walk) m_pend = 1;
        ends = t && (m_elapsed == m_dur - 1 ||
                     ((m_phase == 0 || m_phase == 3) && old_pend && m_elapsed >= MG - 1));
        if (ends) begin
            m_phase   = (m_phase + 1) % 6;
            m_elapsed = 0;
            m_walk    = 0;
            m_dur     = seq_dur[m_phase];
            if ((m_phase == 2 || m_phase == 5) && old_pend) begin
                m_dur = WK; m_walk = 1; m_pend = 0;
            end
        end else if (t) begin
            m_elapsed++;
        end
    endfunction

    task automatic model_check(string name);
        if (m_flash)
            check(name, 3'd6, m_lit ? YL : O, m_lit ? YL : O, 1'b0, 0);
        else
            check(name, 3'(m_phase), lamp_ns[m_phase], lamp_ew[m_phase], m_walk,
                  m_dur - 1 - m_elapsed);
    endtask

    task automatic clk_cycle(bit t, bit p, bit f, bit use_model);
        sec_tick = t; ped_btn = p; flash_en = f;
        @(posedge clk);
        if (use_model) model_step(t, p, f);
        #1;
        if (use_model) model_check("rand");
    endtask

    // One tick slot: tick on the first clk, optional button on the second, flash level held.
    task automatic slot(bit t, bit p, bit f);
        clk_cycle(t, 1'b0, f, 1'b0);
        clk_cycle(1'b0, p, f, 1'b0);
        clk_cycle(1'b0, 1'b0, f, 1'b0);
        clk_cycle(1'b0, 1'b0, f, 1'b0);
    endtask

    typedef struct {
        bit         t, p, f;
        logic [2:0] st, ns, ew;
        bit         w;
        int         left;
    } vec_t;
    vec_t vecs[$];

    task automatic add(bit t, bit p, bit f, logic [2:0] st, logic [2:0] ns, logic [2:0] ew,
                       bit w, int left);
        vec_t v;
        v.t = t; v.p = p; v.f = f; v.st = st; v.ns = ns; v.ew = ew; v.w = w; v.left = left;
        vecs.push_back(v);
    endtask

    initial begin
        bit fl;
        rst = 1'b1; sec_tick = 1'b0; ped_btn = 1'b0; flash_en = 1'b0;

        // Free-running cycle
        add(1,0,0, 0,GN,R,0,4); add(1,0,0, 0,GN,R,0,3); add(1,0,0, 0,GN,R,0,2);
        add(1,0,0, 0,GN,R,0,1); add(1,0,0, 0,GN,R,0,0); add(1,0,0, 1,YL,R,0,1);
        add(1,0,0, 1,YL,R,0,0); add(1,0,0, 2,R,R,0,0);  add(1,0,0, 3,R,GN,0,4);
        add(1,0,0, 3,R,GN,0,3); add(1,0,0, 3,R,GN,0,2); add(1,0,0, 3,R,GN,0,1);
        add(1,0,0, 3,R,GN,0,0); add(1,0,0, 4,R,YL,0,1); add(1,0,0, 4,R,YL,0,0);
        add(1,0,0, 5,R,R,0,0);
        // Button in first green tick: green cut after 2 ticks, walk all-red
        add(1,1,0, 0,GN,R,0,4); add(1,0,0, 0,GN,R,0,3); add(1,0,0, 1,YL,R,0,1);
        add(1,0,0, 1,YL,R,0,0); add(1,0,0, 2,R,R,1,2);  add(1,0,0, 2,R,R,1,1);
        add(1,0,0, 2,R,R,1,0);  add(1,0,0, 3,R,GN,0,4); add(1,0,0, 3,R,GN,0,3);
        add(1,0,0, 3,R,GN,0,2); add(1,0,0, 3,R,GN,0,1); add(1,0,0, 3,R,GN,0,0);
        add(1,0,0, 4,R,YL,0,1); add(1,0,0, 4,R,YL,0,0); add(1,0,0, 5,R,R,0,0);
        add(1,0,0, 0,GN,R,0,4);
        // Button before the 4th green tick; press during walk ignored
        add(1,0,0, 0,GN,R,0,3); add(1,0,0, 0,GN,R,0,2); add(1,1,0, 0,GN,R,0,1);
        add(1,0,0, 1,YL,R,0,1); add(1,0,0, 1,YL,R,0,0); add(1,0,0, 2,R,R,1,2);
        add(1,1,0, 2,R,R,1,1);  add(1,0,0, 2,R,R,1,0);  add(1,0,0, 3,R,GN,0,4);
        add(1,0,0, 3,R,GN,0,3); add(1,0,0, 3,R,GN,0,2); add(1,0,0, 3,R,GN,0,1);
        add(1,0,0, 3,R,GN,0,0); add(1,0,0, 4,R,YL,0,1); add(1,0,0, 4,R,YL,0,0);
        add(1,0,0, 5,R,R,0,0);  add(1,0,0, 0,GN,R,0,4);
        // Flash entered mid EW green on a tick
        add(1,0,0, 0,GN,R,0,3); add(1,0,0, 0,GN,R,0,2); add(1,0,0, 0,GN,R,0,1);
        add(1,0,0, 0,GN,R,0,0); add(1,0,0, 1,YL,R,0,1); add(1,0,0, 1,YL,R,0,0);
        add(1,0,0, 2,R,R,0,0);  add(1,0,0, 3,R,GN,0,4); add(1,0,0, 3,R,GN,0,3);
        add(1,0,1, 6,YL,YL,0,0); add(1,0,1, 6,O,O,0,0); add(1,0,1, 6,YL,YL,0,0);
        add(0,0,0, 5,R,R,0,0);  add(1,0,0, 0,GN,R,0,4);
        // Walk into NS yellow for the async reset case
        add(1,0,0, 0,GN,R,0,3); add(1,0,0, 0,GN,R,0,2); add(1,0,0, 0,GN,R,0,1);
        add(1,0,0, 0,GN,R,0,0); add(1,0,0, 1,YL,R,0,1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 3'd5, R, R, 1'b0, 0);
        rst = 1'b0;
        #1;
        check("reset_released", 3'd5, R, R, 1'b0, 0);

        foreach (vecs[i]) begin
            slot(vecs[i].t, vecs[i].p, vecs[i].f);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ns, vecs[i].ew, vecs[i].w, vecs[i].left);
            $display("vec %0d: tick=%0d ped=%0d flash=%0d -> state=%0d ns=%b ew=%b walk=%0d left=%0d",
                     i, vecs[i].t, vecs[i].p, vecs[i].f, state_o, ns_light, ew_light, walk, phase_left);
        end

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1 check("async_rst", 3'd5, R, R, 1'b0, 0);
        #1 rst = 1'b0;
        slot(1'b0, 1'b0, 1'b0);
        check("post_rst_idle", 3'd5, R, R, 1'b0, 0);
        slot(1'b1, 1'b0, 1'b0);
        check("post_rst_green", 3'd0, GN, R, 1'b0, 4);
        $display("async reset: state=%0d left=%0d", state_o, phase_left);

        // No ticks: everything holds, in green and in flash
        for (int k = 1; k <= 50; k++) begin
            clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (k % 10 == 0) check($sformatf("hold_green_%0d", k), 3'd0, GN, R, 1'b0, 4);
        end
        for (int k = 1; k <= 50; k++) begin
            clk_cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (k % 10 == 0) check($sformatf("hold_flash_%0d", k), 3'd6, YL, YL, 1'b0, 0);
        end
        clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("flash_exit", 3'd5, R, R, 1'b0, 0);
        $display("hold: state=%0d ns=%b ew=%b", state_o, ns_light, ew_light);

        // Randomized run against the reference model
        sec_tick = 1'b0; ped_btn = 1'b0; flash_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        model_check("rand_reset");
        fl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            bit t, p;
            t = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) fl = ~fl;
            clk_cycle(t, p, fl, 1'b1);
        end
        $display("random: 4000 cycles applied");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
